in_bits: RTL and testbench

- Decoder-side counterpart of the arithmetic encoder's bit-emission stage.
- Takes the current decoder interval bounds and finds the common leading bits of upper/lower.
- Shifts that many bits out of the bounds: upper refilled with 1s, lower refilled with 0s.
- Shifts the code register left by the same count, refilling from a buffered compressed bitstream delivered as 16-bit words.

---
 rtl/in_bits.sv | 205 ++++++++++++++++++++
 tb/tb_in_bits.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/in_bits.sv
`default_nettype none
// ============================================================================
//  Module   : in_bits
//  Purpose  : Arithmetic-decoder bit intake. Finds the common leading bits of
//             the interval bounds, shifts them out (upper refilled with 1s,
//             lower refilled with 0s) and shifts the code register by the
//             same count, refilling it from a buffered compressed bitstream.
//  Revision : 1.0  initial release
// ============================================================================
module in_bits #(
    parameter int WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 word_in,
    input  logic                             word_valid,
    input  logic                             word_last,
    output logic                             word_ready,
    input  logic [WIDTH-1:0]                 data_upper_in,
    input  logic [WIDTH-1:0]                 data_lower_in,
    input  logic                             bounds_valid,
    output logic                             bounds_ready,
    output logic [WIDTH-1:0]                 data_upper_out,
    output logic [WIDTH-1:0]                 data_lower_out,
    output logic [WIDTH-1:0]                 code_out,
    output logic [$clog2(WIDTH+1)-1:0]       shift_count,
    output logic                             out_valid
);

    localparam int CW = $clog2(WIDTH + 1);      // shift count width
    localparam int FW = $clog2(2 * WIDTH + 1);  // reservoir fill width

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_STALL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2*WIDTH-1:0]     r_res;
    logic [FW-1:0]          r_fill;
    logic                   r_last_seen;
    logic [WIDTH-1:0]       r_code;
    logic [WIDTH-1:0]       r_req_upper;
    logic [WIDTH-1:0]       r_req_lower;
    logic [WIDTH-1:0]       r_upper_out;
    logic [WIDTH-1:0]       r_lower_out;
    logic [WIDTH-1:0]       r_code_out;
    logic [CW-1:0]          r_shift_cnt;

    logic                   w_word_acc;
    logic [WIDTH-1:0]       w_sel_upper;
    logic [WIDTH-1:0]       w_sel_lower;
    logic [WIDTH-1:0]       w_xor;
    logic [CW-1:0]          w_lzc;
    logic                   w_found;
    logic                   w_bits_ok;
    logic                   w_capture;
    logic                   w_do_init;
    logic                   w_do_shift;
    logic [CW-1:0]          w_consume;
    logic [2*WIDTH-1:0]     w_res_cons;
    logic [FW-1:0]          w_fill_cons;
    logic [2*WIDTH-1:0]     w_res_next;
    logic [FW-1:0]          w_fill_next;
    logic [2*WIDTH-1:0]     w_code_cat;
    logic [2*WIDTH-1:0]     w_upper_cat;
    logic [2*WIDTH-1:0]     w_lower_cat;

    assign word_ready   = (r_fill <= FW'(WIDTH)) && !r_last_seen;
    assign w_word_acc   = word_valid && word_ready;
    assign bounds_ready = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);

    // A fresh request is evaluated straight from the inputs; a stalled one
    // is replayed from the captured copy.
    assign w_sel_upper = (r_state == ST_IDLE) ? data_upper_in : r_req_upper;
    assign w_sel_lower = (r_state == ST_IDLE) ? data_lower_in : r_req_lower;
    assign w_xor       = w_sel_upper ^ w_sel_lower;

    // Leading-zero count of upper^lower; equal bounds give the full width.
    always_comb begin
        w_lzc   = CW'(WIDTH);
        w_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && w_xor[i]) begin
                w_lzc   = CW'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

    // Enough buffered bits, or the stream has ended and zeros pad the tail.
    assign w_bits_ok = (r_fill >= FW'(w_lzc)) || r_last_seen;

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_do_init    = 1'b0;
        w_do_shift   = 1'b0;
        w_consume    = '0;
        case (r_state)
            ST_INIT: begin
                if ((r_fill >= FW'(WIDTH)) || r_last_seen) begin
                    w_do_init    = 1'b1;
                    w_consume    = CW'(WIDTH);
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bounds_valid) begin
                    w_capture = 1'b1;
                    if (w_bits_ok) begin
                        w_do_shift   = 1'b1;
                        w_consume    = w_lzc;
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (w_bits_ok) begin
                    w_do_shift   = 1'b1;
                    w_consume    = w_lzc;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Reservoir update: drop consumed bits first, then append any accepted
    // word right below the surviving bits. Bits below the fill level are
    // always zero, which is what supplies the tail padding.
    always_comb begin
        w_res_cons  = r_res << w_consume;
        w_fill_cons = (r_fill >= FW'(w_consume)) ? (r_fill - FW'(w_consume)) : '0;
        w_res_next  = w_res_cons;
        w_fill_next = w_fill_cons;
        if (w_word_acc) begin
            w_res_next  = w_res_cons | ({word_in, {WIDTH{1'b0}}} >> w_fill_cons);
            w_fill_next = w_fill_cons + FW'(WIDTH);
        end
    end

    // Shifted results: the upper half of a double-width shift carries the
    // refill bits in from the low half, covering counts 0..WIDTH.
    assign w_code_cat  = {r_code, r_res[2*WIDTH-1:WIDTH]} << w_lzc;
    assign w_upper_cat = {w_sel_upper, {WIDTH{1'b1}}} << w_lzc;
    assign w_lower_cat = {w_sel_lower, {WIDTH{1'b0}}} << w_lzc;

    // State, reservoir, request capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_res       <= '0;
            r_fill      <= '0;
            r_last_seen <= 1'b0;
            r_code      <= '0;
            r_req_upper <= '0;
            r_req_lower <= '0;
            r_upper_out <= '0;
            r_lower_out <= '0;
            r_code_out  <= '0;
            r_shift_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_res   <= w_res_next;
            r_fill  <= w_fill_next;
            if (w_word_acc && word_last) begin
                r_last_seen <= 1'b1;
            end
            if (w_capture) begin
                r_req_upper <= data_upper_in;
                r_req_lower <= data_lower_in;
            end
            if (w_do_init) begin
                r_code <= r_res[2*WIDTH-1:WIDTH];
            end
            if (w_do_shift) begin
                r_code      <= w_code_cat[2*WIDTH-1:WIDTH];
                r_code_out  <= w_code_cat[2*WIDTH-1:WIDTH];
                r_upper_out <= w_upper_cat[2*WIDTH-1:WIDTH];
                r_lower_out <= w_lower_cat[2*WIDTH-1:WIDTH];
                r_shift_cnt <= w_lzc;
            end
        end
    end

    assign data_upper_out = r_upper_out;
    assign data_lower_out = r_lower_out;
    assign code_out       = r_code_out;
    assign shift_count    = r_shift_cnt;

endmodule
`default_nettype wire

// File: tb/tb_in_bits.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in_bits
//  Purpose  : Directed self-checking bench for in_bits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_in_bits;

    logic        clk;
    logic        rst;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_last;
    logic        word_ready;
    logic [15:0] data_upper_in;
    logic [15:0] data_lower_in;
    logic        bounds_valid;
    logic        bounds_ready;
    logic [15:0] data_upper_out;
    logic [15:0] data_lower_out;
    logic [15:0] code_out;
    logic [4:0]  shift_count;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    in_bits #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .word_in        (word_in),
        .word_valid     (word_valid),
        .word_last      (word_last),
        .word_ready     (word_ready),
        .data_upper_in  (data_upper_in),
        .data_lower_in  (data_lower_in),
        .bounds_valid   (bounds_valid),
        .bounds_ready   (bounds_ready),
        .data_upper_out (data_upper_out),
        .data_lower_out (data_lower_out),
        .code_out       (code_out),
        .shift_count    (shift_count),
        .out_valid      (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; word_in = '0; word_valid = 1'b0; word_last = 1'b0;
        data_upper_in = '0; data_lower_in = '0; bounds_valid = 1'b0;
        do_reset();

        // Reset state
        chk("rst_out_valid",    out_valid, 0);
        chk("rst_bounds_ready", bounds_ready, 0);
        chk("rst_word_ready",   word_ready, 1);
        chk("rst_upper",        data_upper_out, 0);
        chk("rst_lower",        data_lower_out, 0);
        chk("rst_code",         code_out, 0);
        chk("rst_count",        shift_count, 0);
        chk("rst_fill",         dut.r_fill, 0);

        // Init: A5C3 then 1234
        word_in = 16'hA5C3; word_valid = 1'b1;
        step();
        word_in = 16'h1234;
        step();
        word_valid = 1'b0;
        chk("init_bounds_ready", bounds_ready, 1);
        chk("init_fill",         dut.r_fill, 16);
        chk("init_word_ready",   word_ready, 1);

        data_upper_in = 16'h71BB; data_lower_in = 16'h5876; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("s1_out_valid", out_valid, 1);
        chk("s1_count",     shift_count, 2);
        chk("s1_upper",     data_upper_out, 16'hC6EF);
        chk("s1_lower",     data_lower_out, 16'h61D8);
        chk("s1_code",      code_out, 16'h970C);
        chk("s1_bready",    bounds_ready, 0);
        chk("s1_fill",      dut.r_fill, 14);
        step();
        chk("s1_pulse_end", out_valid, 0);

        // Continue
        data_upper_in = 16'hFFFF; data_lower_in = 16'hF000; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("s2_out_valid", out_valid, 1);
        chk("s2_count",     shift_count, 4);
        chk("s2_code",      code_out, 16'h70C4);
        chk("s2_upper",     data_upper_out, 16'hFFFF);
        chk("s2_lower",     data_lower_out, 16'h0000);
        chk("s2_fill",      dut.r_fill, 10);
        step();

        // Zero count
        data_upper_in = 16'h8000; data_lower_in = 16'h7FFF; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("z_out_valid", out_valid, 1);
        chk("z_count",     shift_count, 0);
        chk("z_upper",     data_upper_out, 16'h8000);
        chk("z_lower",     data_lower_out, 16'h7FFF);
        chk("z_code",      code_out, 16'h70C4);
        chk("z_fill",      dut.r_fill, 10);
        step();
        chk("z_pulse_end", out_valid, 0);
        chk("z_hold_code", code_out, 16'h70C4);

        // Stall
        do_reset();
        word_in = 16'hA5C3; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        chk("st_bready_idle", bounds_ready, 1);
        data_upper_in = 16'h71BB; data_lower_in = 16'h5876; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("st_out_valid0", out_valid, 0);
        chk("st_bready0",    bounds_ready, 0);
        step();
        chk("st_out_valid1", out_valid, 0);
        chk("st_bready1",    bounds_ready, 0);
        word_in = 16'h1234; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        chk("st_out_valid2", out_valid, 0);
        step();
        chk("st_out_valid3", out_valid, 1);
        chk("st_code",       code_out, 16'h970C);
        chk("st_count",      shift_count, 2);
        chk("st_upper",      data_upper_out, 16'hC6EF);
        step();

        // Tail padding
        do_reset();
        word_in = 16'hFFFF; word_valid = 1'b1; word_last = 1'b1;
        step();
        word_valid = 1'b0; word_last = 1'b0;
        chk("tp_word_ready0", word_ready, 0);
        step();
        chk("tp_bready", bounds_ready, 1);
        data_upper_in = 16'h1234; data_lower_in = 16'h1234; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("tp_out_valid",   out_valid, 1);
        chk("tp_count",       shift_count, 16);
        chk("tp_code",        code_out, 16'h0000);
        chk("tp_upper",       data_upper_out, 16'hFFFF);
        chk("tp_lower",       data_lower_out, 16'h0000);
        chk("tp_word_ready1", word_ready, 0);
        step();

        // Reset in STALL with a word arriving
        do_reset();
        word_in = 16'hA5C3; word_valid = 1'b1;
        step();
        word_valid = 1'b0;
        step();
        data_upper_in = 16'h8000; data_lower_in = 16'h7FFF; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("rs_pre_upper", data_upper_out, 16'h8000);
        chk("rs_pre_code",  code_out, 16'hA5C3);
        step();
        data_upper_in = 16'h71BB; data_lower_in = 16'h5876; bounds_valid = 1'b1;
        step();
        bounds_valid = 1'b0;
        chk("rs_stalled", bounds_ready, 0);
        rst = 1'b1; word_in = 16'h1234; word_valid = 1'b1;
        step();
        rst = 1'b0; word_valid = 1'b0;
        chk("rs_fill",       dut.r_fill, 0);
        chk("rs_bready",     bounds_ready, 0);
        chk("rs_out_valid",  out_valid, 0);
        chk("rs_upper",      data_upper_out, 0);
        chk("rs_lower",      data_lower_out, 0);
        chk("rs_code",       code_out, 0);
        chk("rs_word_ready", word_ready, 1);
        step();
        chk("rs_fill_after", dut.r_fill, 0);
        chk("rs_still_init", bounds_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
